// File: rtl/masked_share_rf.sv
// masked_share_rf: masked-share register file with WRITE/REMASK/ARK ops.
// Optional ZEROIZE op (op 3) is built when MASKED_RF_ZEROIZE_EN is defined.
module masked_share_rf #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 16,
  parameter int GROUP    = 4,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int HALF    = GROUP / 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [AW-1:0]     dst_i,
  input  logic [AW-1:0]     src_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [DATA_W-1:0] rnd_i,
  input  logic              rnd_valid_i,
  output logic              rnd_ready_o,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_REMASK = 2'd1;
  localparam logic [1:0] OP_ARK    = 2'd2;

  localparam logic [AW-1:0] K_REM_LAST = AW'(HALF - 1);
  localparam logic [AW-1:0] K_ARK_LAST = AW'(GROUP - 1);
  localparam logic [AW-1:0] HALF_OFS   = AW'(HALF);

`ifdef MASKED_RF_ZEROIZE_EN
  localparam logic [1:0]    OP_ZERO     = 2'd3;
  localparam logic [AW-1:0] K_ZERO_LAST = AW'(NUM_REGS - 1);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REMASK = 2'd1,
    S_ARK    = 2'd2,
    S_ZERO   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REMASK = 2'd1,
    S_ARK    = 2'd2
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [AW-1:0]       dst_q, src_q, k_q;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic                done_q, err_q;
  logic                done_d, err_d;
  logic                accept, op_legal, last_step;
  logic [AW-1:0]       a_dst, a_src, a_hi, w_hi;

  assign accept = req_i && (state_q == S_IDLE);
  assign a_dst  = dst_q + k_q;
  assign a_src  = src_q + k_q;
  assign a_hi   = dst_q + k_q + HALF_OFS;
  assign w_hi   = dst_i + AW'(1);

  // Decode which op codes this build supports.
  always_comb begin
    op_legal = 1'b0;
    unique case (op_i)
      OP_WRITE, OP_REMASK, OP_ARK: op_legal = 1'b1;
`ifdef MASKED_RF_ZEROIZE_EN
      OP_ZERO: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // Flag the edge on which the final step of a multi-cycle op is written.
  always_comb begin
    last_step = 1'b0;
    unique case (state_q)
      S_REMASK: last_step = rnd_valid_i && (k_q == K_REM_LAST);
      S_ARK:    last_step = (k_q == K_ARK_LAST);
`ifdef MASKED_RF_ZEROIZE_EN
      S_ZERO:   last_step = (k_q == K_ZERO_LAST);
`endif
      default:  last_step = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op_i)
            OP_REMASK: state_d = S_REMASK;
            OP_ARK:    state_d = S_ARK;
`ifdef MASKED_RF_ZEROIZE_EN
            OP_ZERO:   state_d = S_ZERO;
`endif
            default:   state_d = S_IDLE;
          endcase
        end
      end
      default: if (last_step) state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready_o     = (state_q == S_IDLE);
    rnd_ready_o = (state_q == S_REMASK) && rnd_valid_i;
    done_d      = last_step || (accept && op_i == OP_WRITE);
    err_d       = accept && !op_legal;
  end

  // Completion / error pulses, registered so they appear the cycle after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign done_o = done_q;
  assign err_o  = err_q;

  // Register file and operand pointers; one step per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      dst_q <= '0;
      src_q <= '0;
      k_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            dst_q <= dst_i;
            src_q <= src_i;
            k_q   <= '0;
            if (op_i == OP_WRITE) begin
              rf_q[dst_i] <= wdata0_i;
              rf_q[w_hi]  <= wdata1_i;
            end
          end
        end
        S_REMASK: begin
          if (rnd_valid_i) begin
            rf_q[a_dst] <= rf_q[a_src] ^ rnd_i;
            rf_q[a_hi]  <= rnd_i;
            k_q         <= k_q + AW'(1);
          end
        end
        S_ARK: begin
          rf_q[a_dst] <= rf_q[a_dst] ^ rf_q[a_src];
          k_q         <= k_q + AW'(1);
        end
`ifdef MASKED_RF_ZEROIZE_EN
        S_ZERO: begin
          rf_q[k_q] <= '0;
          k_q       <= k_q + AW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  assign rdata_o = rd_en_i ? rf_q[rd_addr_i] : '0;

endmodule

// File: tb/tb_masked_share_rf.sv
// tb_masked_share_rf: random + directed scoreboard bench for masked_share_rf.
// Event and read-data expectations are queued; a monitor checks them.
module tb_masked_share_rf;
  localparam int DW = 64;
  localparam int NR = 16;
  localparam int GR = 4;
  localparam int HF = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_i = 1'b0;
  logic [1:0]    op_i = '0;
  logic [AW-1:0] dst_i = '0, src_i = '0, rd_addr_i = '0;
  logic [DW-1:0] wdata0_i = '0, wdata1_i = '0, rnd_i = '0;
  logic          rnd_valid_i = 1'b0, rd_en_i = 1'b0;
  logic          rnd_ready_o, ready_o, done_o, err_o;
  logic [DW-1:0] rdata_o;

  masked_share_rf dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .op_i(op_i),
    .dst_i(dst_i), .src_i(src_i), .wdata0_i(wdata0_i),
    .wdata1_i(wdata1_i), .rnd_i(rnd_i), .rnd_valid_i(rnd_valid_i),
    .rnd_ready_o(rnd_ready_o), .ready_o(ready_o), .done_o(done_o),
    .err_o(err_o), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rdata_o(rdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int at;
  } ev_t;

  ev_t           evq[$];
  logic [DW-1:0] rdq[$];
  logic [DW-1:0] m[NR];
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event or read.
  always @(negedge clk) begin
    ev_t e;
    #1;
    if (done_o || err_o) begin
      if (evq.size() == 0) begin
        chk("spurious_event", {62'd0, err_o, done_o}, '0);
      end else begin
        e = evq.pop_front();
        chk("event_kind", {62'd0, err_o, done_o}, e.is_err ? 2 : 1);
        chk("event_cycle", DW'(cyc), DW'(e.at));
      end
    end
    if (rd_en_i) begin
      if (rdq.size() == 0) chk("rd_unexpected", rdata_o, 'x);
      else chk("rdata", rdata_o, rdq.pop_front());
    end
  end

  task automatic accept(input logic [1:0] op, input logic [AW-1:0] d,
                        input logic [AW-1:0] s, input logic [DW-1:0] w0,
                        input logic [DW-1:0] w1, output int e);
    @(negedge clk);
    req_i = 1'b1; op_i = op; dst_i = d; src_i = s;
    wdata0_i = w0; wdata1_i = w1;
    @(posedge clk);
    #1;
    e = cyc;
    req_i = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] d, input logic [DW-1:0] w0,
                          input logic [DW-1:0] w1);
    int e;
    accept(2'd0, d, AW'($urandom), w0, w1, e);
    m[d] = w0;
    m[AW'(d + 1)] = w1;
    evq.push_back('{1'b0, e});
  endtask

  task automatic do_remask(input logic [AW-1:0] d, input logic [AW-1:0] s,
                           input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                           input int s0, input int s1);
    int e;
    logic [DW-1:0] r[HF];
    int st[HF];
    r[0] = r0; r[1] = r1; st[0] = s0; st[1] = s1;
    accept(2'd1, d, s, '0, '0, e);
    evq.push_back('{1'b0, e + HF + s0 + s1});
    for (int k = 0; k < HF; k++) begin
      m[AW'(d + k)] = m[AW'(s + k)] ^ r[k];
      m[AW'(d + HF + k)] = r[k];
    end
    @(negedge clk);
    for (int k = 0; k < HF; k++) begin
      for (int j = 0; j < st[k]; j++) begin
        rnd_valid_i = 1'b0;
        rnd_i = {$urandom, $urandom};
        #1 chk("rnd_ready_stall", DW'(rnd_ready_o), 0);
        @(negedge clk);
      end
      rnd_valid_i = 1'b1;
      rnd_i = r[k];
      #1 chk("rnd_ready_step", DW'(rnd_ready_o), 1);
      @(negedge clk);
    end
    rnd_valid_i = 1'b0;
  endtask

  task automatic do_ark(input logic [AW-1:0] d, input logic [AW-1:0] s,
                        input bit hold, input bit abort);
    int e;
    accept(2'd2, d, s, '0, '0, e);
    evq.push_back('{1'b0, e + GR});
    if (hold) begin
      req_i = 1'b1; op_i = 2'd0;
      dst_i = AW'($urandom); wdata0_i = {$urandom, $urandom};
    end
    @(negedge clk);
    rd_en_i = 1'b1; rd_addr_i = d;
    rdq.push_back(m[d]);
    for (int k = 0; k < GR; k++)
      m[AW'(d + k)] = m[AW'(d + k)] ^ m[AW'(s + k)];
    @(negedge clk);
    rd_en_i = 1'b0;
    if (abort) begin
      rst_ni = 1'b0;
      void'(evq.pop_back());
      for (int i = 0; i < NR; i++) m[i] = '0;
      #1;
      chk("rst_ready", DW'(ready_o), 1);
      chk("rst_done", DW'(done_o), 0);
      @(negedge clk);
      rst_ni = 1'b1;
    end else begin
      repeat (GR - 1) @(negedge clk);
      req_i = 1'b0;
    end
  endtask

  task automatic do_zero();
    int e;
    accept(2'd3, AW'($urandom), AW'($urandom), '0, '0, e);
`ifdef MASKED_RF_ZEROIZE_EN
    evq.push_back('{1'b0, e + NR});
    for (int i = 0; i < NR; i++) m[i] = '0;
    repeat (NR) @(negedge clk);
`else
    evq.push_back('{1'b1, e});
`endif
  endtask

  task automatic sweep();
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      rd_en_i = 1'b1; rd_addr_i = AW'(i);
      rdq.push_back(m[i]);
    end
    @(negedge clk);
    rd_en_i = 1'b0;
    #1 chk("rd_disabled", rdata_o, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) m[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", DW'(ready_o), 1);
    chk("reset_done", DW'(done_o), 0);
    chk("reset_err", DW'(err_o), 0);
    chk("reset_rnd_ready", DW'(rnd_ready_o), 0);
    sweep();
    @(negedge clk);
    rst_ni = 1'b1;

    do_write(4'd5, 64'hAA, 64'hBB);
    do_write(4'd0, 64'h11, 64'h22);
    do_remask(4'd8, 4'd0, 64'hF0, 64'h0F, 0, 2);
    sweep();
    do_write(4'd14, 64'd1, 64'd2);
    do_write(4'd0, 64'd3, 64'd4);
    do_write(4'd4, 64'h10, 64'h11);
    do_write(4'd6, 64'h12, 64'h13);
    do_ark(4'd14, 4'd4, 1'b1, 1'b0);
    sweep();
    do_write(4'd3, 64'h33, 64'h44);
    do_ark(4'd3, 4'd3, 1'b0, 1'b0);
    sweep();
    do_zero();
    sweep();
    do_write(4'd2, 64'h5A, 64'hA5);
    do_ark(4'd1, 4'd9, 1'b0, 1'b1);
    sweep();
    repeat (8) @(negedge clk);

    for (int it = 0; it < 60; it++) begin
      logic [AW-1:0] d, s;
      d = AW'($urandom);
      s = AW'($urandom);
      case ($urandom_range(0, 7))
        0, 1, 2: do_write(d, {$urandom, $urandom}, {$urandom, $urandom});
        3, 4: do_remask(d, s, {$urandom, $urandom}, {$urandom, $urandom},
                        $urandom_range(0, 2), $urandom_range(0, 2));
        5, 6: do_ark(d, s, $urandom_range(0, 1) == 1, 1'b0);
        default: do_zero();
      endcase
      if (it % 8 == 7) sweep();
    end
    sweep();
    repeat (4) @(negedge clk);
    chk("pending_events", DW'(evq.size()), 0);
    chk("pending_reads", DW'(rdq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
